// File: rtl/alu_seq_muldiv.sv
// Multi-cycle EX-stage ALU: single-cycle RV32I ops plus iterative RV32M multiply
// (shift-add) and divide/remainder (restoring), one bit per cycle, start/busy/done handshake.
module alu_seq_muldiv #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] ALUControl,
  input  logic [XLEN-1:0] Read_data1,
  input  logic [XLEN-1:0] ALU_in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic [1:0]      state_dbg
);

  // Handshake: start is sampled only on edges where busy=0 (including the done cycle);
  // done is a one-cycle pulse and ALUResult/Zero then hold until the next result is written.

  localparam int CW = $clog2(XLEN);

  localparam logic [OP_W-1:0] OP_AND   = OP_W'(5'b00000);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(5'b00001);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(5'b00010);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5'b00100);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(5'b00101);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(5'b00110);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(5'b00111);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(5'b01000);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(5'b01001);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(5'b10000);
  localparam logic [OP_W-1:0] OP_MULH  = OP_W'(5'b10001);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(5'b10010);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(5'b10100);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(5'b10101);
  localparam logic [OP_W-1:0] OP_REM   = OP_W'(5'b10110);
  localparam logic [OP_W-1:0] OP_REMU  = OP_W'(5'b10111);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [OP_W-1:0] op_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic            neg_res_q;
  logic            neg_rem_q;

  logic            is_mul;
  logic            is_div;
  logic            a_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic [CW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] div_special_res;
  logic [XLEN-1:0] single_res;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  assign is_mul   = ALUControl inside {OP_MUL, OP_MULH, OP_MULHU};
  assign is_div   = ALUControl inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign a_signed = ALUControl inside {OP_MULH, OP_DIV, OP_REM};
  assign a_neg    = a_signed & Read_data1[XLEN-1];
  assign b_neg    = a_signed & ALU_in2[XLEN-1];
  assign a_mag    = a_neg ? -Read_data1 : Read_data1;
  assign b_mag    = b_neg ? -ALU_in2 : ALU_in2;
  assign div_zero = (ALU_in2 == '0);
  assign div_ovf  = (ALUControl inside {OP_DIV, OP_REM}) && (Read_data1 == MIN_NEG)
                    && (ALU_in2 == '1);
  assign shamt    = ALU_in2[CW-1:0];

  always_comb begin
    alu_res = Read_data1 & ALU_in2;
    case (ALUControl)
      OP_AND:  alu_res = Read_data1 & ALU_in2;
      OP_OR:   alu_res = Read_data1 | ALU_in2;
      OP_ADD:  alu_res = Read_data1 + ALU_in2;
      OP_SUB:  alu_res = Read_data1 - ALU_in2;
      OP_XOR:  alu_res = Read_data1 ^ ALU_in2;
      OP_SLL:  alu_res = Read_data1 << shamt;
      OP_SRL:  alu_res = Read_data1 >> shamt;
      OP_SRA:  alu_res = $signed(Read_data1) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(Read_data1) < $signed(ALU_in2))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (Read_data1 < ALU_in2)};
      default: alu_res = Read_data1 & ALU_in2;
    endcase
  end

  // Divide-by-zero and signed overflow finish in IDLE without entering the divider.
  always_comb begin
    div_special_res = '0;
    if (div_zero) begin
      div_special_res = (ALUControl inside {OP_DIV, OP_DIVU}) ? '1 : Read_data1;
    end else if (div_ovf) begin
      div_special_res = (ALUControl == OP_DIV) ? Read_data1 : '0;
    end
  end

  assign single_res = is_div ? div_special_res : alu_res;

  // Multiply step: {hi,lo} holds partial product and remaining multiplier bits.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, lo_q[XLEN-1:1]};

  // Divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [XLEN:0]   div_shift;
  logic            div_ok;
  logic [XLEN-1:0] div_rem_next;
  logic [XLEN-1:0] div_quo_next;

  assign div_shift    = {hi_q, lo_q[XLEN-1]};
  assign div_ok       = (div_shift >= {1'b0, opnd_q});
  assign div_rem_next = div_ok ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
  assign div_quo_next = {lo_q[XLEN-2:0], div_ok};

  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   fix_res;

  assign prod_signed = neg_res_q ? -{hi_q, lo_q} : {hi_q, lo_q};

  always_comb begin
    fix_res = lo_q;
    case (op_q)
      OP_MUL:   fix_res = lo_q;
      OP_MULH:  fix_res = prod_signed[2*XLEN-1:XLEN];
      OP_MULHU: fix_res = hi_q;
      OP_DIV:   fix_res = neg_res_q ? -lo_q : lo_q;
      OP_DIVU:  fix_res = lo_q;
      OP_REM:   fix_res = neg_rem_q ? -hi_q : hi_q;
      OP_REMU:  fix_res = hi_q;
      default:  fix_res = lo_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q      <= ALUControl;
            cnt       <= '0;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (is_mul) begin
              hi_q   <= '0;
              lo_q   <= b_mag;
              opnd_q <= a_mag;
              state  <= S_MUL;
            end else if (is_div && !div_zero && !div_ovf) begin
              hi_q   <= '0;
              lo_q   <= a_mag;
              opnd_q <= b_mag;
              state  <= S_DIV;
            end else begin
              ALUResult <= single_res;
              Zero      <= (single_res == '0);
              done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          {hi_q, lo_q} <= mul_next;
          cnt          <= cnt + CW'(1);
          if (cnt == LAST_CNT) state <= S_FIX;
        end
        S_DIV: begin
          hi_q <= div_rem_next;
          lo_q <= div_quo_next;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_CNT) state <= S_FIX;
        end
        S_FIX: begin
          ALUResult <= fix_res;
          Zero      <= (fix_res == '0);
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv: vector table of single ops with expected result and
// latency, plus hand sequences for mid-op start, reset abort and back-to-back starts.
module tb_alu_seq_muldiv;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_XOR   = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SRL   = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SLT   = 5'b00111;
  localparam logic [4:0] OP_SRA   = 5'b01000;
  localparam logic [4:0] OP_SLTU  = 5'b01001;
  localparam logic [4:0] OP_BAD   = 5'b01111;
  localparam logic [4:0] OP_MUL   = 5'b10000;
  localparam logic [4:0] OP_MULH  = 5'b10001;
  localparam logic [4:0] OP_MULHU = 5'b10010;
  localparam logic [4:0] OP_DIV   = 5'b10100;
  localparam logic [4:0] OP_DIVU  = 5'b10101;
  localparam logic [4:0] OP_REM   = 5'b10110;
  localparam logic [4:0] OP_REMU  = 5'b10111;
  localparam int NV = 28;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  ALUControl;
  logic [31:0] Read_data1;
  logic [31:0] ALU_in2;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;
  logic [1:0]  state_dbg;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [NV];

  alu_seq_muldiv #(.XLEN(32), .OP_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .Read_data1 (Read_data1),
    .ALU_in2    (ALU_in2),
    .busy       (busy),
    .done       (done),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one start pulse and wait (bounded) for done; lat=1 means done in the cycle after the edge.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output int busy_cnt, output bit to);
    @(negedge clk);
    ALUControl = op;
    Read_data1 = a;
    ALU_in2    = b;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    to       = 1'b0;
    while (!done) begin
      if (busy) busy_cnt++;
      if (lat >= 100) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    res = ALUResult;
    z   = Zero;
  endtask

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat;
    int          bcnt;
    bit          to;
    int          extra_done;

    n_checks = 0;
    n_errors = 0;

    vecs[0]  = '{OP_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[1]  = '{OP_OR,    32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1};
    vecs[2]  = '{OP_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1};
    vecs[3]  = '{OP_SUB,   32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1};
    vecs[4]  = '{OP_XOR,   32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1};
    vecs[5]  = '{OP_SLL,   32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1};
    vecs[6]  = '{OP_SRL,   32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1};
    vecs[7]  = '{OP_SRA,   32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1};
    vecs[8]  = '{OP_SLT,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
    vecs[9]  = '{OP_SLTU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[10] = '{OP_BAD,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1};
    vecs[11] = '{OP_ADD,   32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};
    vecs[12] = '{OP_MUL,   32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 34};
    vecs[13] = '{OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[14] = '{OP_MULH,  32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[15] = '{OP_MULH,  32'h4000_0000, 32'h4000_0000, 32'h1000_0000, 34};
    vecs[16] = '{OP_MULH,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 34};
    vecs[17] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[18] = '{OP_REM,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[19] = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[20] = '{OP_REMU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1};
    vecs[21] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[22] = '{OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[23] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 34};
    vecs[24] = '{OP_REMU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 34};
    vecs[25] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vecs[26] = '{OP_REM,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[27] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34};

    reset      = 1'b1;
    start      = 1'b0;
    ALUControl = '0;
    Read_data1 = '0;
    ALU_in2    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", ALUResult, 32'd0);
    check("reset zero", {31'b0, Zero}, 32'd0);
    check("reset state", {30'b0, state_dbg}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, bcnt, to);
      check($sformatf("vec%0d timeout", i), {31'b0, to}, 32'd0);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d zero", i), {31'b0, z}, {31'b0, (vecs[i].exp == 32'd0)});
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].lat - 1));
      check($sformatf("vec%0d busy at done", i), {31'b0, busy}, 32'd0);
    end

    // start pulsed mid-MUL with different operands must be ignored
    @(negedge clk);
    ALUControl = OP_MUL;
    Read_data1 = 32'hFFFF_FFFD;
    ALU_in2    = 32'h0000_0007;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    to    = 1'b0;
    while (!done) begin
      if (lat == 5) begin
        ALUControl = OP_ADD;
        Read_data1 = 32'h0000_0001;
        ALU_in2    = 32'h0000_0001;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (lat >= 100) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("midmul timeout", {31'b0, to}, 32'd0);
    check("midmul result", ALUResult, 32'hFFFF_FFEB);
    check("midmul latency", 32'(lat), 32'd34);
    extra_done = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
    end
    check("midmul extra done", 32'(extra_done), 32'd0);

    // reset mid-DIV (with start also high) aborts and clears outputs
    @(negedge clk);
    ALUControl = OP_DIVU;
    Read_data1 = 32'h0000_0064;
    ALU_in2    = 32'h0000_0007;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("prereset busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    reset      = 1'b1;
    start      = 1'b1;
    ALUControl = OP_ADD;
    Read_data1 = 32'h0000_0001;
    ALU_in2    = 32'h0000_0001;
    @(posedge clk);
    #1;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort result", ALUResult, 32'd0);
    check("abort state", {30'b0, state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    run_op(OP_SUB, 32'd5, 32'd5, res, z, lat, bcnt, to);
    check("post reset sub result", res, 32'd0);
    check("post reset sub zero", {31'b0, z}, 32'd1);
    check("post reset sub latency", 32'(lat), 32'd1);

    // start held across two edges: second op accepted in the first op's done cycle
    @(negedge clk);
    ALUControl = OP_ADD;
    Read_data1 = 32'd2;
    ALU_in2    = 32'd3;
    start      = 1'b1;
    @(posedge clk);
    #1;
    check("b2b first done", {31'b0, done}, 32'd1);
    check("b2b first result", ALUResult, 32'd5);
    ALUControl = OP_SUB;
    Read_data1 = 32'd9;
    ALU_in2    = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b second done", {31'b0, done}, 32'd1);
    check("b2b second result", ALUResult, 32'd7);
    @(posedge clk);
    #1;
    check("b2b done drops", {31'b0, done}, 32'd0);
    check("b2b result holds", ALUResult, 32'd7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
